instr_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the on-chip instruction ROM (1-port, registered, ROM_LAT edges).

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/fetch_pc_counter.sv | 30 +++
 rtl/instr_fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and default sizes for the instruction fetch sequencer.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      PRESENT,
      DONE
   } fetch_state_t;

   localparam int DEF_ADDR_W    = 7;
   localparam int DEF_INSTR_W   = 16;
   localparam int DEF_ROM_LAT   = 2;
   localparam int DEF_LAST_ADDR = 127;

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter register: clear, increment, and (with FETCH_JUMP_EN) load.
module fetch_pc_counter
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
`ifdef FETCH_JUMP_EN
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
`endif
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pc <= '0;
`ifdef FETCH_JUMP_EN
      end else if (load) begin
         pc <= load_addr;
`endif
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction ROM fetch sequencer: PC ownership, ROM latency wait, valid/ready hand-off.
// Optional jump redirect on transfer is enabled by defining FETCH_JUMP_EN.
module instr_fetch_ctrl
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int INSTR_W   = DEF_INSTR_W,
   parameter int LAST_ADDR = DEF_LAST_ADDR,
   parameter int ROM_LAT   = DEF_ROM_LAT
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Stop,
   output logic [ADDR_W-1:0]  RomAddr,
   input  logic [INSTR_W-1:0] RomQ,
   output logic [INSTR_W-1:0] InstrData,
   output logic [ADDR_W-1:0]  InstrPC,
   output logic               InstrValid,
   input  logic               InstrReady,
`ifdef FETCH_JUMP_EN
   input  logic               JumpEn,
   input  logic [ADDR_W-1:0]  JumpAddr,
`endif
   output logic               Busy,
   output logic               Done
);

   localparam int CNT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
   localparam logic [CNT_W-1:0]  LAT_RELOAD = CNT_W'(ROM_LAT);
   localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(LAST_ADDR);

   fetch_state_t      state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0] pc;
   logic              xfer;
   logic              jump;
   logic              pc_clr;
   logic              pc_inc;
`ifdef FETCH_JUMP_EN
   logic              pc_load;

   assign jump = JumpEn;
`else
   assign jump = 1'b0;
`endif

   assign RomAddr = pc;
   assign xfer    = (state == PRESENT) && InstrValid && InstrReady;

   // Stop outranks Start, which outranks the handshake; a jump outranks the end check.
   always_comb begin
      pc_clr = Stop || (Start && ((state == IDLE) || (state == DONE)));
      pc_inc = !Stop && xfer && !jump && (pc != LAST);
`ifdef FETCH_JUMP_EN
      pc_load = !Stop && xfer && jump;
`endif
   end

   fetch_pc_counter #(
      .ADDR_W (ADDR_W)
   ) u_pc (
      .clk       (Clk),
      .rst       (Reset),
      .clr       (pc_clr),
      .inc       (pc_inc),
`ifdef FETCH_JUMP_EN
      .load      (pc_load),
      .load_addr (JumpAddr),
`endif
      .pc        (pc)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         InstrData  <= '0;
         InstrPC    <= '0;
         InstrValid <= 1'b0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
      end else if (Stop) begin
         state      <= IDLE;
         InstrValid <= 1'b0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state    <= WAIT;
                  wait_cnt <= LAT_RELOAD;
                  Busy     <= 1'b1;
                  Done     <= 1'b0;
               end
            end
            // RomQ for the current PC is valid once the counter has run down to zero.
            WAIT: begin
               if (wait_cnt == '0) begin
                  InstrData  <= RomQ;
                  InstrPC    <= pc;
                  InstrValid <= 1'b1;
                  state      <= PRESENT;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            PRESENT: begin
               if (xfer) begin
                  InstrValid <= 1'b0;
                  if (!jump && (pc == LAST)) begin
                     state <= DONE;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= LAT_RELOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl against a ROM_LAT-edge ROM model holding 16'hA000+addr.
module tb_instr_fetch_ctrl;

   localparam int ADDR_W    = 7;
   localparam int INSTR_W   = 16;
   localparam int LAST_ADDR = 127;
   localparam int ROM_LAT   = 2;

   logic               Clk;
   logic               Reset;
   logic               Start;
   logic               Stop;
   logic [ADDR_W-1:0]  RomAddr;
   logic [INSTR_W-1:0] RomQ;
   logic [INSTR_W-1:0] InstrData;
   logic [ADDR_W-1:0]  InstrPC;
   logic               InstrValid;
   logic               InstrReady;
`ifdef FETCH_JUMP_EN
   logic               JumpEn;
   logic [ADDR_W-1:0]  JumpAddr;
`endif
   logic               Busy;
   logic               Done;

   int n_tests = 0;
   int n_fail  = 0;

   instr_fetch_ctrl #(
      .ADDR_W    (ADDR_W),
      .INSTR_W   (INSTR_W),
      .LAST_ADDR (LAST_ADDR),
      .ROM_LAT   (ROM_LAT)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .Stop       (Stop),
      .RomAddr    (RomAddr),
      .RomQ       (RomQ),
      .InstrData  (InstrData),
      .InstrPC    (InstrPC),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
`ifdef FETCH_JUMP_EN
      .JumpEn     (JumpEn),
      .JumpAddr   (JumpAddr),
`endif
      .Busy       (Busy),
      .Done       (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Registered ROM: address captured on one edge, data emerges ROM_LAT edges after the change.
   logic [INSTR_W-1:0] rom_pipe [ROM_LAT];
   always @(posedge Clk) begin
      rom_pipe[0] <= INSTR_W'(16'hA000 + INSTR_W'(RomAddr));
      for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign RomQ = rom_pipe[ROM_LAT-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_pc(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && !(InstrValid && (int'(InstrPC) == target)); i++) tick();
      check(tag, {InstrValid, InstrPC}, {1'b1, ADDR_W'(target)});
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int exp_pc;
      int bad;
      Reset = 1'b1; Start = 1'b0; Stop = 1'b0; InstrReady = 1'b0;
`ifdef FETCH_JUMP_EN
      JumpEn = 1'b0; JumpAddr = '0;
`endif
      // 1: reset values
      repeat (3) tick();
      check("rst_valid", InstrValid, 0);
      check("rst_data",  InstrData, 0);
      check("rst_ipc",   InstrPC, 0);
      check("rst_addr",  RomAddr, 0);
      check("rst_busy",  Busy, 0);
      check("rst_done",  Done, 0);
      Reset = 1'b0;
      tick();
      check("idle_valid", InstrValid, 0);
      check("idle_busy",  Busy, 0);

      // 2: start latency and streaming rate
      InstrReady = 1'b1;
      pulse_start();
      check("start_busy",  Busy, 1);
      check("start_addr",  RomAddr, 0);
      check("start_valid", InstrValid, 0);
      tick(); tick();
      check("lat_valid_early", InstrValid, 0);
      tick();
      check("first_valid", InstrValid, 1);
      check("first_data",  InstrData, 16'hA000);
      check("first_ipc",   InstrPC, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("gap_valid", InstrValid, 0);
         repeat (3) tick();
         check("stream_valid", InstrValid, 1);
         check("stream_data",  InstrData, 32'hA000 + k);
         check("stream_ipc",   InstrPC, k);
      end

      // 3: back-pressure hold at PC=5, Start ignored while busy
      repeat (4) tick();
      InstrReady = 1'b0;
      check("pre_hold_data", InstrData, 16'hA005);
      repeat (5) tick();
      pulse_start();
      repeat (4) tick();
      check("hold_valid", InstrValid, 1);
      check("hold_data",  InstrData, 16'hA005);
      check("hold_ipc",   InstrPC, 5);
      check("hold_addr",  RomAddr, 5);
      InstrReady = 1'b1;
      repeat (4) tick();
      check("resume_data", InstrData, 16'hA006);
      check("resume_ipc",  InstrPC, 6);

      // 4: run to end of program, then restart
      exp_pc = 6;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         if (InstrValid) begin
            if ((int'(InstrPC) != exp_pc) || (InstrData != INSTR_W'(16'hA000 + exp_pc))) bad++;
            if (int'(InstrPC) == LAST_ADDR) break;
            exp_pc++;
         end
         tick();
      end
      check("seq_errors", bad, 0);
      check("last_seen", {InstrValid, InstrPC}, {1'b1, 7'd127});
      tick();
      check("end_done",  Done, 1);
      check("end_busy",  Busy, 0);
      check("end_valid", InstrValid, 0);
      repeat (5) tick();
      check("done_sticky", Done, 1);
      pulse_start();
      check("restart_done", Done, 0);
      check("restart_busy", Busy, 1);
      repeat (3) tick();
      check("restart_data", InstrData, 16'hA000);
      check("restart_ipc",  InstrPC, 0);

      // 5: Stop in WAIT at PC=40, then Reset while PRESENT
      wait_pc("reach_39", 39, 400);
      tick();
      check("wait40_addr",  RomAddr, 40);
      check("wait40_valid", InstrValid, 0);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      check("stop_valid", InstrValid, 0);
      check("stop_addr",  RomAddr, 0);
      check("stop_busy",  Busy, 0);
      check("stop_done",  Done, 0);
      repeat (5) tick();
      check("stop_idle_valid", InstrValid, 0);
      InstrReady = 1'b0;
      pulse_start();
      repeat (3) tick();
      check("pres_valid", InstrValid, 1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_rst_valid", InstrValid, 0);
      check("mid_rst_data",  InstrData, 0);
      check("mid_rst_ipc",   InstrPC, 0);
      check("mid_rst_addr",  RomAddr, 0);
      check("mid_rst_busy",  Busy, 0);
      tick();
      check("post_rst_valid", InstrValid, 0);

`ifdef FETCH_JUMP_EN
      // 6: jump on transfer, including at the last address
      InstrReady = 1'b1;
      pulse_start();
      wait_pc("reach_10", 10, 100);
      JumpEn = 1'b1; JumpAddr = 7'd100;
      tick();
      JumpEn = 1'b0;
      check("jump_addr", RomAddr, 100);
      repeat (3) tick();
      check("jump_data", InstrData, 16'hA064);
      check("jump_ipc",  InstrPC, 100);
      wait_pc("reach_127", 127, 200);
      JumpEn = 1'b1;
      tick();
      JumpEn = 1'b0;
      check("jump_end_done", Done, 0);
      check("jump_end_busy", Busy, 1);
      repeat (3) tick();
      check("jump_end_data", InstrData, 16'hA064);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
